// File: rtl/regfile_scoreboard_if.sv
// Writeback, decode-read and issue/kill bundle for regfile_scoreboard.
// The master drives the pipeline-side strobes and the slave is the register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            wr_en_in;
    logic [4:0]      rd_addr_in;
    logic [XLEN-1:0] rd_value_in;
    logic [4:0]      rs1_addr_in;
    logic [4:0]      rs2_addr_in;
    logic [XLEN-1:0] rs1_value_out;
    logic [XLEN-1:0] rs2_value_out;
    logic            issue_en_in;
    logic [4:0]      issue_rd_addr_in;
    logic            kill_en_in;
    logic [4:0]      kill_rd_addr_in;
    logic            rs1_busy_out;
    logic            rs2_busy_out;
    logic            hazard_stall_out;
    logic            pend_overflow_out;

    modport master (
        output wr_en_in, rd_addr_in, rd_value_in,
        output rs1_addr_in, rs2_addr_in,
        output issue_en_in, issue_rd_addr_in, kill_en_in, kill_rd_addr_in,
        input  rs1_value_out, rs2_value_out,
        input  rs1_busy_out, rs2_busy_out, hazard_stall_out, pend_overflow_out
    );

    modport slave (
        input  wr_en_in, rd_addr_in, rd_value_in,
        input  rs1_addr_in, rs2_addr_in,
        input  issue_en_in, issue_rd_addr_in, kill_en_in, kill_rd_addr_in,
        output rs1_value_out, rs2_value_out,
        output rs1_busy_out, rs2_busy_out, hazard_stall_out, pend_overflow_out
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-first bypass and per-register pending-write counters.
// Define REGFILE_CLEAR_ON_RESET_EN to also clear the register storage on reset.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int PEND_W   = 2
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave rf_bus
);
    localparam int AW       = 5;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic [XLEN-1:0]   r_regs      [1:NUM_REGS-1];
    logic [PEND_W-1:0] r_pend      [1:NUM_REGS-1];
    logic [PEND_W-1:0] w_pend_next [1:NUM_REGS-1];
    logic              r_overflow;
    logic              w_overflow_hit;
    logic              w_wr_valid;
    logic [XLEN-1:0]   w_rs1_value;
    logic [XLEN-1:0]   w_rs2_value;
    logic              w_rs1_busy;
    logic              w_rs2_busy;
    int                w_sum;

    assign w_wr_valid = rf_bus.wr_en_in && (rf_bus.rd_addr_in != '0);

    // Without the clear option the array has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
`ifdef REGFILE_CLEAR_ON_RESET_EN
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[rf_bus.rd_addr_in] <= rf_bus.rd_value_in;
        end
`else
        if (!rst && w_wr_valid) begin
            r_regs[rf_bus.rd_addr_in] <= rf_bus.rd_value_in;
        end
`endif
    end

    always_comb begin
        w_rs1_value = '0;
        if (rf_bus.rs1_addr_in != '0) begin
            if (w_wr_valid && (rf_bus.rd_addr_in == rf_bus.rs1_addr_in)) begin
                w_rs1_value = rf_bus.rd_value_in;
            end else begin
                w_rs1_value = r_regs[rf_bus.rs1_addr_in];
            end
        end
    end

    always_comb begin
        w_rs2_value = '0;
        if (rf_bus.rs2_addr_in != '0) begin
            if (w_wr_valid && (rf_bus.rd_addr_in == rf_bus.rs2_addr_in)) begin
                w_rs2_value = rf_bus.rd_value_in;
            end else begin
                w_rs2_value = r_regs[rf_bus.rs2_addr_in];
            end
        end
    end

    // A writeback retiring this cycle satisfies one pending write; issue/kill are ignored here.
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        if (rf_bus.rs1_addr_in != '0) begin
            if (w_wr_valid && (rf_bus.rd_addr_in == rf_bus.rs1_addr_in)) begin
                w_rs1_busy = r_pend[rf_bus.rs1_addr_in] > PEND_W'(1);
            end else begin
                w_rs1_busy = r_pend[rf_bus.rs1_addr_in] != '0;
            end
        end
        if (rf_bus.rs2_addr_in != '0) begin
            if (w_wr_valid && (rf_bus.rd_addr_in == rf_bus.rs2_addr_in)) begin
                w_rs2_busy = r_pend[rf_bus.rs2_addr_in] > PEND_W'(1);
            end else begin
                w_rs2_busy = r_pend[rf_bus.rs2_addr_in] != '0;
            end
        end
    end

    // Net delta per register is -2..+1; clamp into [0, PEND_MAX].
    always_comb begin
        w_overflow_hit = 1'b0;
        w_sum          = 0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_sum = int'(r_pend[r])
                  + ((rf_bus.issue_en_in && (rf_bus.issue_rd_addr_in == AW'(r))) ? 1 : 0)
                  - ((w_wr_valid && (rf_bus.rd_addr_in == AW'(r))) ? 1 : 0)
                  - ((rf_bus.kill_en_in && (rf_bus.kill_rd_addr_in == AW'(r))) ? 1 : 0);
            if (w_sum < 0) begin
                w_pend_next[r] = '0;
            end else if (w_sum > PEND_MAX) begin
                w_pend_next[r] = PEND_W'(PEND_MAX);
                w_overflow_hit = 1'b1;
            end else begin
                w_pend_next[r] = PEND_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_pend[r] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_pend[r] <= w_pend_next[r];
            end
            if (w_overflow_hit) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rf_bus.rs1_value_out     = w_rs1_value;
    assign rf_bus.rs2_value_out     = w_rs2_value;
    assign rf_bus.rs1_busy_out      = w_rs1_busy;
    assign rf_bus.rs2_busy_out      = w_rs2_busy;
    assign rf_bus.hazard_stall_out  = w_rs1_busy | w_rs2_busy;
    assign rf_bus.pend_overflow_out = r_overflow;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table, hand-written reset sequence and a random
// read/write phase, all checked through an expected-value queue.
module tb_regfile_scoreboard;
    localparam int XLEN = 32;
    localparam int EW   = 2 * XLEN + 5;
`ifdef REGFILE_CLEAR_ON_RESET_EN
    localparam logic CLEAR_BUILD = 1'b1;
`else
    localparam logic CLEAR_BUILD = 1'b0;
`endif

    typedef struct {
        logic            wr;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            iss;
        logic [4:0]      ird;
        logic            kill;
        logic [4:0]      krd;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic            eb1;
        logic            eb2;
        logic            eovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   step_id;

    // {check_values, rs1_value, rs2_value, rs1_busy, rs2_busy, stall, overflow}
    logic [EW-1:0]   exp_q[$];
    vec_t            vecs[$];
    logic [XLEN-1:0] model[32];
    bit              written[32];

    regfile_scoreboard_if #(.XLEN(XLEN)) rf_bus ();

    regfile_scoreboard #(
        .NUM_REGS(32),
        .XLEN(XLEN),
        .PEND_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf_bus(rf_bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // drivers
    task automatic drive(input logic wr, input logic [4:0] rd, input logic [XLEN-1:0] val,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic iss, input logic [4:0] ird,
                         input logic kill, input logic [4:0] krd);
        rf_bus.wr_en_in         = wr;
        rf_bus.rd_addr_in       = rd;
        rf_bus.rd_value_in      = val;
        rf_bus.rs1_addr_in      = rs1;
        rf_bus.rs2_addr_in      = rs2;
        rf_bus.issue_en_in      = iss;
        rf_bus.issue_rd_addr_in = ird;
        rf_bus.kill_en_in       = kill;
        rf_bus.kill_rd_addr_in  = krd;
    endtask

    task automatic push_exp(input logic chk_vals, input logic [XLEN-1:0] e1,
                            input logic [XLEN-1:0] e2, input logic eb1, input logic eb2,
                            input logic eovf);
        exp_q.push_back({chk_vals, e1, e2, eb1, eb2, eb1 | eb2, eovf});
    endtask

    // scoreboard
    task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_id, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard step %0d: got empty queue expected an entry", step_id);
            return;
        end
        e = exp_q.pop_front();
        if (e[EW-1]) begin
            cmp("rs1_value", rf_bus.rs1_value_out, e[2*XLEN+3:XLEN+4]);
            cmp("rs2_value", rf_bus.rs2_value_out, e[XLEN+3:4]);
        end
        cmp("rs1_busy", {31'd0, rf_bus.rs1_busy_out}, {31'd0, e[3]});
        cmp("rs2_busy", {31'd0, rf_bus.rs2_busy_out}, {31'd0, e[2]});
        cmp("hazard_stall", {31'd0, rf_bus.hazard_stall_out}, {31'd0, e[1]});
        cmp("pend_overflow", {31'd0, rf_bus.pend_overflow_out}, {31'd0, e[0]});
    endtask

    task automatic sample_and_advance();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        step_id++;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        step_id = 0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        do_reset();

        //         wr    rd     val           rs1    rs2    iss   ird    kill  krd    e1            e2            eb1   eb2   eovf
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd10, 32'h12345678, 5'd5,  5'd10, 1'b0, 5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd10, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd3,  32'h33,       5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  32'h33,       32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  32'h33,       32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  32'h33,       32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  32'h33,       32'h0,        1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h33,       32'h0,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd3,  32'h44,       5'd3,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h44,       32'h0,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd4,  32'h40,       5'd0,  5'd4,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h40,       1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b1, 5'd4,  1'b0, 5'd0,  32'h40,       32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h40,       32'h0,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd4,  32'h4444,     5'd4,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h4444,     32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h4444,     32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd6,  32'h66,       5'd6,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h66,       32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd6,  5'd0,  1'b1, 5'd6,  1'b0, 5'd0,  32'h66,       32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd6,  1'b1, 5'd6,  1'b0, 5'd0,  32'h0,        32'h66,       1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 5'd6,  32'h6666,     5'd6,  5'd0,  1'b1, 5'd6,  1'b1, 5'd6,  32'h6666,     32'h0,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd6,  5'd6,  1'b0, 5'd0,  1'b0, 5'd0,  32'h6666,     32'h6666,     1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd6,  1'b0, 5'd0,  1'b1, 5'd6,  32'h0,        32'h6666,     1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd6,  1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h6666,     1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd6,  32'h77,       5'd6,  5'd0,  1'b0, 5'd0,  1'b1, 5'd6,  32'h77,       32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd6,  5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  32'h77,       32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].val, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].iss, vecs[i].ird, vecs[i].kill, vecs[i].krd);
            push_exp(1'b1, vecs[i].e1, vecs[i].e2, vecs[i].eb1, vecs[i].eb2, vecs[i].eovf);
            sample_and_advance();
        end

        // Mid-stream reset: x3 still has two pending writes and overflow is set.
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(1'b1, 32'h44, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        sample_and_advance();

        // During reset the bypass still shows, and this write and issue must be dropped.
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
        push_exp(1'b1, 32'h44, 32'h55, 1'b1, 1'b0, 1'b1);
        sample_and_advance();
        rst = 1'b0;

        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(CLEAR_BUILD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        sample_and_advance();

        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(CLEAR_BUILD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        sample_and_advance();

        // Random reads and writes with no issues outstanding.
        foreach (written[i]) written[i] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic            wr;
            logic [4:0]      rd;
            logic [4:0]      rs1;
            logic [4:0]      rs2;
            logic [XLEN-1:0] val;
            logic [XLEN-1:0] e1;
            logic [XLEN-1:0] e2;
            wr  = 1'($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            val = $urandom;
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            if (!written[rs1] && !(wr && rd == rs1)) rs1 = 5'd0;
            if (!written[rs2] && !(wr && rd == rs2)) rs2 = 5'd0;
            e1 = (rs1 == 5'd0) ? 32'h0 : ((wr && rd == rs1) ? val : model[rs1]);
            e2 = (rs2 == 5'd0) ? 32'h0 : ((wr && rd == rs2) ? val : model[rs2]);
            drive(wr, rd, val, rs1, rs2, 1'b0, 5'd0, 1'b0, 5'd0);
            push_exp(1'b1, e1, e2, 1'b0, 1'b0, 1'b0);
            sample_and_advance();
            if (wr && rd != 5'd0) begin
                model[rd]   = val;
                written[rd] = 1'b1;
            end
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
